regfile_mux_bank: RTL and testbench

- Parametrised register bank: one write port, NUM_RD independent registered read ports, plus a sequential dump engine that streams every entry out in index order.
- Successor to the flat 64x16 combinational register select.
- Sits between the control/config interface and datapath consumers that need several register values per cycle.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_rd_port.sv | 66 ++++++
 rtl/regfile_mux_bank.sv | 213 +++++++++++++++++++++
 tb/tb_regfile_mux_bank.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_mux_bank block.
//   dump_state_t : dump sequencer states
//   MAX_RD       : largest supported number of read ports
//   par_f        : even-parity helper (XOR-reduce). Data is zero-extended
//                  to PAR_MAX_W, which does not change its parity.
package regfile_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } dump_state_t;

   localparam int MAX_RD    = 4;
   localparam int PAR_MAX_W = 64;

   function automatic logic par_f(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of the register bank.
// The index range check, the write-first bypass and the one-cycle output
// register live here. The parent supplies the entry already selected by
// rd_idx, along with that entry's parity status.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rd_req, rd_idx   read request and index for this port
//   wr_en            qualified write strobe (index already range-checked)
//   wr_idx, wr_data  write index and data, used for the bypass
//   wr_bad           the data being written will be stored with bad parity
//   entry_data       stored entry at rd_idx
//   entry_bad        stored entry at rd_idx fails its parity check
//   rd_valid, rd_data, rd_err  registered results, one cycle after rd_req
module regfile_rd_port #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 64,
   parameter int IDX_W    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_bad,
   input  logic [DATA_W-1:0] entry_data,
   input  logic              entry_bad,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err
);

   // One extra bit so that NUM_REGS = 2**IDX_W is representable.
   localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

   logic in_range;
   logic bypass;

   assign in_range = ({1'b0, rd_idx} < NREGS);
   assign bypass   = wr_en && (wr_idx == rd_idx);

   // rd_data and rd_err hold their last value when no request is made.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            if (!in_range) begin
               rd_data <= '0;
               rd_err  <= 1'b1;
            end else if (bypass) begin
               rd_data <= wr_data;
               rd_err  <= wr_bad;
            end else begin
               rd_data <= entry_data;
               rd_err  <= entry_bad;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mux_bank.sv
// Parametrised register bank: one write port, NUM_RD registered read ports
// (1-cycle latency, write-first bypass) and a dump engine that streams every
// entry out in index order with a valid/ready handshake.
// Optional build macro REGFILE_PARITY_EN adds per-entry even parity, the
// dump_err output and the test-only inj_par_err input.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_en, wr_idx, wr_data       write port (out-of-range index ignored)
//   rd_req, rd_idx               per-port request / index (packed)
//   rd_valid, rd_data, rd_err    per-port registered results (packed)
//   dump_start, dump_ready       start pulse, downstream ready
//   dump_valid, dump_idx, dump_data, dump_busy   dump stream and status
//   inj_par_err, dump_err        parity build only
//
// Dump sequencer:
//   state | meaning
//   IDLE  | waiting for dump_start
//   SWEEP | presenting entry dump_idx, advances when dump_ready is high
//   DONE  | one quiet cycle after the last beat, then IDLE
module regfile_mux_bank
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 64,
   parameter int NUM_RD   = 2,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD-1:0]        rd_req,
   input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
   output logic [NUM_RD-1:0]        rd_valid,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_err,
`ifdef REGFILE_PARITY_EN
   input  logic                     inj_par_err,
   output logic                     dump_err,
`endif
   input  logic                     dump_start,
   input  logic                     dump_ready,
   output logic                     dump_valid,
   output logic [IDX_W-1:0]         dump_idx,
   output logic [DATA_W-1:0]        dump_data,
   output logic                     dump_busy
);

   localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);
   localparam logic [IDX_W:0] LAST  = (IDX_W+1)'(NUM_REGS - 1);

   logic [DATA_W-1:0] mem [NUM_REGS];
`ifdef REGFILE_PARITY_EN
   logic              mem_par [NUM_REGS];
`endif

   logic wr_ok;
   logic wr_bad;

   assign wr_ok = wr_en && ({1'b0, wr_idx} < NREGS);

`ifdef REGFILE_PARITY_EN
   assign wr_bad = inj_par_err;
`else
   assign wr_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
`ifdef REGFILE_PARITY_EN
            mem_par[i] <= 1'b0;
`endif
         end
      end else if (wr_ok) begin
         mem[wr_idx] <= wr_data;
`ifdef REGFILE_PARITY_EN
         mem_par[wr_idx] <= par_f(PAR_MAX_W'(wr_data)) ^ inj_par_err;
`endif
      end
   end

   // Entry select per port. The guard only keeps the array access in bounds;
   // the port itself decides what an out-of-range index returns.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] entry;
      logic              entry_bad;

      assign idx = rd_idx[p*IDX_W +: IDX_W];

      always_comb begin
         entry     = '0;
         entry_bad = 1'b0;
         if ({1'b0, idx} < NREGS) begin
            entry = mem[idx];
`ifdef REGFILE_PARITY_EN
            entry_bad = (par_f(PAR_MAX_W'(mem[idx])) != mem_par[idx]);
`endif
         end
      end

      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .IDX_W    (IDX_W)
      ) u_rd_port (
         .clk        (clk),
         .rst        (rst),
         .rd_req     (rd_req[p]),
         .rd_idx     (idx),
         .wr_en      (wr_ok),
         .wr_idx     (wr_idx),
         .wr_data    (wr_data),
         .wr_bad     (wr_bad),
         .entry_data (entry),
         .entry_bad  (entry_bad),
         .rd_valid   (rd_valid[p]),
         .rd_data    (rd_data[p*DATA_W +: DATA_W]),
         .rd_err     (rd_err[p])
      );
   end

   // Index and contents of the beat to present next cycle. A write landing
   // on that index this cycle is forwarded so the beat shows current contents,
   // which also refreshes a stalled beat one cycle after the write.
   dump_state_t       dump_state;
   logic [IDX_W-1:0]  dump_nidx;
   logic [DATA_W-1:0] dump_ndata;
`ifdef REGFILE_PARITY_EN
   logic              dump_nbad;
`endif

   always_comb begin
      dump_nidx = dump_idx;
      if (dump_state == IDLE) begin
         dump_nidx = '0;
      end else if (dump_ready) begin
         dump_nidx = dump_idx + IDX_W'(1);
      end
      dump_ndata = '0;
`ifdef REGFILE_PARITY_EN
      dump_nbad = 1'b0;
`endif
      if ({1'b0, dump_nidx} < NREGS) begin
         dump_ndata = mem[dump_nidx];
`ifdef REGFILE_PARITY_EN
         dump_nbad = (par_f(PAR_MAX_W'(mem[dump_nidx])) != mem_par[dump_nidx]);
`endif
      end
      if (wr_ok && (wr_idx == dump_nidx)) begin
         dump_ndata = wr_data;
`ifdef REGFILE_PARITY_EN
         dump_nbad = wr_bad;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dump_state <= IDLE;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
         dump_busy  <= 1'b0;
`ifdef REGFILE_PARITY_EN
         dump_err   <= 1'b0;
`endif
      end else begin
         case (dump_state)
            IDLE: begin
               if (dump_start) begin
                  dump_state <= SWEEP;
                  dump_valid <= 1'b1;
                  dump_busy  <= 1'b1;
                  dump_idx   <= dump_nidx;
                  dump_data  <= dump_ndata;
`ifdef REGFILE_PARITY_EN
                  dump_err   <= dump_nbad;
`endif
               end
            end
            SWEEP: begin
               if (dump_ready && ({1'b0, dump_idx} == LAST)) begin
                  dump_state <= DONE;
                  dump_valid <= 1'b0;
                  dump_busy  <= 1'b0;
`ifdef REGFILE_PARITY_EN
                  dump_err   <= 1'b0;
`endif
               end else begin
                  dump_idx  <= dump_nidx;
                  dump_data <= dump_ndata;
`ifdef REGFILE_PARITY_EN
                  dump_err  <= dump_nbad;
`endif
               end
            end
            DONE: begin
               dump_state <= IDLE;
            end
            default: begin
               dump_state <= IDLE;
               dump_valid <= 1'b0;
               dump_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_mux_bank.sv
// Self-checking bench for regfile_mux_bank: a 64-entry / 2-port instance and
// a 48-entry / 1-port instance, checked against an array model of the bank.
module tb_regfile_mux_bank;

   localparam int DW   = 16;
   localparam int NR   = 64;
   localparam int NP   = 2;
   localparam int IW   = 6;
   localparam int NR48 = 48;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            wr_en;
   logic [IW-1:0]   wr_idx;
   logic [DW-1:0]   wr_data;
   logic [NP-1:0]   rd_req;
   logic [NP*IW-1:0] rd_idx;
   logic [NP-1:0]   rd_valid;
   logic [NP*DW-1:0] rd_data;
   logic [NP-1:0]   rd_err;
   logic            dump_start, dump_ready, dump_valid, dump_busy;
   logic [IW-1:0]   dump_idx;
   logic [DW-1:0]   dump_data;

   logic            b_wr_en;
   logic [IW-1:0]   b_wr_idx;
   logic [DW-1:0]   b_wr_data;
   logic            b_rd_req;
   logic [IW-1:0]   b_rd_idx;
   logic            b_rd_valid;
   logic [DW-1:0]   b_rd_data;
   logic            b_rd_err;
   logic            b_dump_start, b_dump_ready, b_dump_valid, b_dump_busy;
   logic [IW-1:0]   b_dump_idx;
   logic [DW-1:0]   b_dump_data;

`ifdef REGFILE_PARITY_EN
   logic inj_par_err, dump_err, b_inj_par_err, b_dump_err;
`endif

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] model   [NR];
   logic [DW-1:0] model48 [NR48];
   logic [DW-1:0] exp_data [NP];

   regfile_mux_bank #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_idx     (rd_idx),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
`ifdef REGFILE_PARITY_EN
      .inj_par_err(inj_par_err),
      .dump_err   (dump_err),
`endif
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy)
   );

   regfile_mux_bank #(.DATA_W(DW), .NUM_REGS(NR48), .NUM_RD(1)) dut48 (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (b_wr_en),
      .wr_idx     (b_wr_idx),
      .wr_data    (b_wr_data),
      .rd_req     (b_rd_req),
      .rd_idx     (b_rd_idx),
      .rd_valid   (b_rd_valid),
      .rd_data    (b_rd_data),
      .rd_err     (b_rd_err),
`ifdef REGFILE_PARITY_EN
      .inj_par_err(b_inj_par_err),
      .dump_err   (b_dump_err),
`endif
      .dump_start (b_dump_start),
      .dump_ready (b_dump_ready),
      .dump_valid (b_dump_valid),
      .dump_idx   (b_dump_idx),
      .dump_data  (b_dump_data),
      .dump_busy  (b_dump_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_idx = '0; wr_data = '0;
      rd_req = '0; rd_idx = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      b_wr_en = 1'b0; b_wr_idx = '0; b_wr_data = '0;
      b_rd_req = 1'b0; b_rd_idx = '0;
      b_dump_start = 1'b0; b_dump_ready = 1'b0;
`ifdef REGFILE_PARITY_EN
      inj_par_err = 1'b0; b_inj_par_err = 1'b0;
`endif
   endtask

   task automatic clear_models();
      for (int i = 0; i < NR; i++) model[i] = '0;
      for (int i = 0; i < NR48; i++) model48[i] = '0;
      for (int p = 0; p < NP; p++) exp_data[p] = '0;
   endtask

   // Reset with every other input active: reset must win, including the write.
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      wr_en = 1'b1; wr_idx = '0; wr_data = 16'hFFFF;
      rd_req = '1; rd_idx = '0; dump_start = 1'b1; dump_ready = 1'b1;
      b_wr_en = 1'b1; b_wr_data = 16'hFFFF; b_dump_start = 1'b1;
      tick();
      tick();
      checks++;
      if (rd_valid !== '0 || rd_data !== '0 || rd_err !== '0)
         begin errors++; $display("FAIL reset_rd: valid=%b data=%h err=%b want 0", rd_valid, rd_data, rd_err); end
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== '0 || dump_data !== '0)
         begin errors++; $display("FAIL reset_dump: valid=%b busy=%b idx=%0d data=%h want 0", dump_valid, dump_busy, dump_idx, dump_data); end
      rst = 1'b0;
      idle_inputs();
      clear_models();
      tick();
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0)
         begin errors++; $display("FAIL reset_idle: dump_valid=%b busy=%b want 0", dump_valid, dump_busy); end
      for (int i = 0; i < NR; i++) begin
         rd_req = 2'b11;
         rd_idx = {IW'(NR - 1 - i), IW'(i)};
         tick();
         checks++;
         if (rd_valid !== 2'b11)
            begin errors++; $display("FAIL reset_read_valid i=%0d: got %b want 11", i, rd_valid); end
         checks++;
         if (rd_data !== '0 || rd_err !== '0)
            begin errors++; $display("FAIL reset_read_data i=%0d: data=%h err=%b want 0", i, rd_data, rd_err); end
      end
      idle_inputs();
      tick();
      checks++;
      if (rd_valid !== '0 || rd_data !== '0)
         begin errors++; $display("FAIL read_idle_hold: valid=%b data=%h want 0/0", rd_valid, rd_data); end
   endtask

   task automatic test_write_read();
      idle_inputs();
      wr_en = 1'b1; wr_idx = 6'd5; wr_data = 16'hBEEF;
      model[5] = 16'hBEEF;
      tick();
      idle_inputs();
      rd_req = 2'b10; rd_idx[IW +: IW] = 6'd5;
      exp_data[1] = model[5];
      tick();
      checks++;
      if (rd_valid !== 2'b10 || rd_data[DW +: DW] !== 16'hBEEF || rd_err[1] !== 1'b0)
         begin errors++; $display("FAIL write_read: valid=%b data1=%h err1=%b want 10/beef/0", rd_valid, rd_data[DW +: DW], rd_err[1]); end
      checks++;
      if (rd_data[0 +: DW] !== exp_data[0])
         begin errors++; $display("FAIL write_read_hold0: got %h want %h", rd_data[0 +: DW], exp_data[0]); end
      idle_inputs();
   endtask

   task automatic test_bypass();
      idle_inputs();
      wr_en = 1'b1; wr_idx = 6'd7; wr_data = 16'h1234;
      rd_req = 2'b11; rd_idx = {6'd7, 6'd7};
      model[7] = 16'h1234;
      exp_data[0] = 16'h1234; exp_data[1] = 16'h1234;
      tick();
      idle_inputs();
      checks++;
      if (rd_valid !== 2'b11 || rd_data !== {16'h1234, 16'h1234} || rd_err !== 2'b00)
         begin errors++; $display("FAIL bypass: valid=%b data=%h err=%b want 11/12341234/00", rd_valid, rd_data, rd_err); end
   endtask

   // Write-first: the model applies this cycle's write before answering reads.
   task automatic test_random();
      logic [IW-1:0] ix [NP];
      logic [NP-1:0] exp_valid;
      for (int n = 0; n < 400; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_idx  = IW'($urandom_range(0, NR - 1));
         wr_data = DW'($urandom);
         rd_req  = NP'($urandom);
         for (int p = 0; p < NP; p++) begin
            ix[p] = ($urandom_range(0, 3) == 0) ? wr_idx : IW'($urandom_range(0, NR - 1));
            rd_idx[p*IW +: IW] = ix[p];
         end
         if (wr_en) model[wr_idx] = wr_data;
         exp_valid = rd_req;
         for (int p = 0; p < NP; p++)
            if (rd_req[p]) exp_data[p] = model[ix[p]];
         tick();
         checks++;
         if (rd_valid !== exp_valid)
            begin errors++; $display("FAIL rand_valid n=%0d: got %b want %b", n, rd_valid, exp_valid); end
         for (int p = 0; p < NP; p++) begin
            checks++;
            if (rd_data[p*DW +: DW] !== exp_data[p] || (exp_valid[p] && rd_err[p] !== 1'b0))
               begin errors++; $display("FAIL rand_data n=%0d p=%0d: got %h err=%b want %h err=0", n, p, rd_data[p*DW +: DW], rd_err[p], exp_data[p]); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_range48();
      int beat;
      int cyc;
      idle_inputs();
      b_rd_req = 1'b1; b_rd_idx = 6'd50;
      tick();
      checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== '0 || b_rd_err !== 1'b1)
         begin errors++; $display("FAIL range48_oor: valid=%b data=%h err=%b want 1/0/1", b_rd_valid, b_rd_data, b_rd_err); end
      b_rd_idx = 6'd47;
      tick();
      checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== '0 || b_rd_err !== 1'b0)
         begin errors++; $display("FAIL range48_last: valid=%b data=%h err=%b want 1/0/0", b_rd_valid, b_rd_data, b_rd_err); end
      b_rd_req = 1'b0;
      for (int i = 0; i < NR48; i++) begin
         b_wr_en = 1'b1; b_wr_idx = IW'(i); b_wr_data = DW'(i + 100);
         model48[i] = DW'(i + 100);
         tick();
      end
      b_wr_idx = 6'd50; b_wr_data = 16'hDEAD;
      tick();
      b_wr_idx = 6'd63; b_wr_data = 16'hDEAD;
      tick();
      b_wr_en = 1'b0;
      b_rd_req = 1'b1; b_rd_idx = 6'd50;
      tick();
      b_rd_req = 1'b0;
      checks++;
      if (b_rd_data !== '0 || b_rd_err !== 1'b1)
         begin errors++; $display("FAIL range48_oor_after_wr: data=%h err=%b want 0/1", b_rd_data, b_rd_err); end
      b_dump_start = 1'b1;
      tick();
      b_dump_start = 1'b0;
      b_dump_ready = 1'b1;
      beat = 0; cyc = 0;
      while (beat < NR48 && cyc < 200) begin
         if (b_dump_valid) begin
            checks++;
            if (b_dump_idx !== IW'(beat) || b_dump_data !== model48[beat])
               begin errors++; $display("FAIL dump48_beat %0d: idx=%0d data=%h want idx=%0d data=%h", beat, b_dump_idx, b_dump_data, beat, model48[beat]); end
            beat++;
         end
         tick();
         cyc++;
      end
      checks++;
      if (beat !== NR48)
         begin errors++; $display("FAIL dump48_count: got %0d beats want %0d", beat, NR48); end
      checks++;
      if (b_dump_valid !== 1'b0 || b_dump_busy !== 1'b0)
         begin errors++; $display("FAIL dump48_done: valid=%b busy=%b want 0/0", b_dump_valid, b_dump_busy); end
      tick();
      checks++;
      if (b_dump_valid !== 1'b0)
         begin errors++; $display("FAIL dump48_extra_beat: valid=%b want 0", b_dump_valid); end
      idle_inputs();
   endtask

   task automatic fill_times3();
      idle_inputs();
      for (int i = 0; i < NR; i++) begin
         wr_en = 1'b1; wr_idx = IW'(i); wr_data = DW'(i * 3);
         model[i] = DW'(i * 3);
         tick();
      end
      idle_inputs();
   endtask

   // Walks the stream with dump_ready toggling; stalled beats are checked too,
   // so any movement during a stall shows up as a wrong index or data.
   task automatic test_dump_toggle();
      int beat;
      int cyc;
      fill_times3();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      beat = 0; cyc = 0;
      while (beat < NR && cyc < 400) begin
         dump_ready = (cyc % 2 == 0);
         if (dump_valid) begin
            checks++;
            if (dump_busy !== 1'b1 || dump_idx !== IW'(beat) || dump_data !== model[beat])
               begin errors++; $display("FAIL dump_beat %0d: busy=%b idx=%0d data=%h want 1/%0d/%h", beat, dump_busy, dump_idx, dump_data, beat, model[beat]); end
            if (dump_ready) beat++;
         end
         tick();
         cyc++;
      end
      dump_ready = 1'b0;
      checks++;
      if (beat !== NR)
         begin errors++; $display("FAIL dump_count: got %0d beats want %0d", beat, NR); end
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0)
         begin errors++; $display("FAIL dump_done: valid=%b busy=%b want 0/0", dump_valid, dump_busy); end
      tick();
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0)
         begin errors++; $display("FAIL dump_idle: valid=%b busy=%b want 0/0", dump_valid, dump_busy); end
   endtask

   task automatic test_dump_stall_write();
      int beat;
      int cyc;
      idle_inputs();
      dump_start = 1'b1;
      tick();
      dump_ready = 1'b0;
      wr_en = 1'b1; wr_idx = '0; wr_data = 16'hA5A5;
      model[0] = 16'hA5A5;
      tick();
      idle_inputs();
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== '0 || dump_data !== 16'hA5A5)
         begin errors++; $display("FAIL dump_stall_write: valid=%b idx=%0d data=%h want 1/0/a5a5", dump_valid, dump_idx, dump_data); end
      dump_ready = 1'b1;
      beat = 0; cyc = 0;
      while (beat < NR && cyc < 200) begin
         if (beat == 10) dump_start = 1'b1;
         else dump_start = 1'b0;
         if (dump_valid) begin
            checks++;
            if (dump_idx !== IW'(beat) || dump_data !== model[beat])
               begin errors++; $display("FAIL dump2_beat %0d: idx=%0d data=%h want %0d/%h", beat, dump_idx, dump_data, beat, model[beat]); end
            beat++;
         end
         tick();
         cyc++;
      end
      idle_inputs();
      checks++;
      if (beat !== NR)
         begin errors++; $display("FAIL dump2_count: got %0d beats want %0d", beat, NR); end
      tick();
      tick();
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0)
         begin errors++; $display("FAIL dump2_no_restart: valid=%b busy=%b want 0/0", dump_valid, dump_busy); end
   endtask

   task automatic test_dump_reset();
      int beat;
      int cyc;
      idle_inputs();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      beat = 0; cyc = 0;
      while (beat < 20 && cyc < 200) begin
         dump_ready = (cyc % 2 == 0);
         if (dump_valid && dump_ready) beat++;
         tick();
         cyc++;
      end
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 6'd20)
         begin errors++; $display("FAIL dump_rst_pre: valid=%b idx=%0d want 1/20", dump_valid, dump_idx); end
      rst = 1'b1;
      dump_ready = 1'b1;
      tick();
      rst = 1'b0;
      clear_models();
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0)
         begin errors++; $display("FAIL dump_rst_after: valid=%b busy=%b want 0/0", dump_valid, dump_busy); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (dump_valid !== 1'b0 || dump_busy !== 1'b0)
            begin errors++; $display("FAIL dump_rst_idle k=%0d: valid=%b busy=%b want 0/0", k, dump_valid, dump_busy); end
      end
      idle_inputs();
      rd_req = 2'b01; rd_idx = 12'd3;
      tick();
      idle_inputs();
      checks++;
      if (rd_data[0 +: DW] !== '0)
         begin errors++; $display("FAIL dump_rst_mem: got %h want 0", rd_data[0 +: DW]); end
   endtask

`ifdef REGFILE_PARITY_EN
   task automatic test_parity();
      idle_inputs();
      wr_en = 1'b1; wr_idx = 6'd3; wr_data = 16'h0F0E; inj_par_err = 1'b1;
      tick();
      wr_idx = 6'd4; wr_data = 16'h0F0E; inj_par_err = 1'b0;
      tick();
      idle_inputs();
      rd_req = 2'b11; rd_idx = {6'd4, 6'd3};
      tick();
      idle_inputs();
      checks++;
      if (rd_err !== 2'b01 || rd_data !== {16'h0F0E, 16'h0F0E})
         begin errors++; $display("FAIL parity_read: err=%b data=%h want 01/0f0e0f0e", rd_err, rd_data); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle_inputs();
      clear_models();
      test_reset();
      test_write_read();
      test_bypass();
      test_random();
      test_range48();
      test_dump_toggle();
      test_dump_stall_write();
      test_dump_reset();
`ifdef REGFILE_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
